// File: rtl/reg_file_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_file_ctrl_if
//   Bundles every link that the register-file command controller talks over:
//   the byte stream arriving from the serial receiver, the register-file
//   access port, and the byte stream leaving for the serial transmitter.
//
//   Signals
//     rx_data   [7:0]             received byte, qualified by rx_valid
//     rx_valid                    one-cycle strobe per received byte
//     WrEn                        register-file write enable
//     RdEn                        register-file read enable
//     Address   [ADDR_WIDTH-1:0]  register-file address
//     WrData    [DATA_WIDTH-1:0]  register-file write data
//     RdData    [DATA_WIDTH-1:0]  register-file read data (valid edge after RdEn)
//     tx_data   [7:0]             byte offered to the transmitter
//     tx_valid                    tx_data valid, held until accepted
//     tx_ready                    transmitter accepts on tx_valid & tx_ready
//     err                         one-cycle protocol error pulse
//
//   Modports
//     master : the controller (drives register-file and transmitter side)
//     slave  : the environment (receiver, register file, transmitter)
// ---------------------------------------------------------------------------
interface reg_file_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  err;

  // The controller consumes received bytes and read data, and produces
  // register-file commands, transmit bytes and the error pulse.
  modport master (
    input  rx_data,
    input  rx_valid,
    input  RdData,
    input  tx_ready,
    output WrEn,
    output RdEn,
    output Address,
    output WrData,
    output tx_data,
    output tx_valid,
    output err
  );

  // The surrounding logic sees the mirror image of the controller.
  modport slave (
    output rx_data,
    output rx_valid,
    output RdData,
    output tx_ready,
    input  WrEn,
    input  RdEn,
    input  Address,
    input  WrData,
    input  tx_data,
    input  tx_valid,
    input  err
  );

endinterface

// File: rtl/reg_file_ctrl.sv
// ---------------------------------------------------------------------------
// reg_file_ctrl
//   Turns a byte stream from the serial receiver into register-file
//   transactions and sends read results back to the serial transmitter.
//
//   Frames
//     write : WR_CMD, addr, NB data bytes (least significant byte first)
//     read  : RD_CMD, addr      -> NB bytes returned, LSB first
//
//   Ports
//     CLK   in   system clock, rising edge
//     RST   in   asynchronous reset, active-low
//     bus   master modport of reg_file_ctrl_if (rx link, register-file
//           port, tx link, err pulse)
//
//   Parameters
//     DATA_WIDTH  register width, multiple of 8 (NB = DATA_WIDTH/8)
//     ADDR_WIDTH  register address width, at most 8
//     WR_CMD      write opcode byte
//     RD_CMD      read opcode byte
//
//   Every output comes straight from a flop, so there is no combinational
//   path from rx/tx inputs to any output.
// ---------------------------------------------------------------------------
module reg_file_ctrl #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 3,
  parameter logic [7:0] WR_CMD     = 8'hAA,
  parameter logic [7:0] RD_CMD     = 8'hBB
) (
  input  logic            CLK,
  input  logic            RST,
  reg_file_ctrl_if.master bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(NB) + 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    WRITE,
    R_ADDR,
    READ,
    R_WAIT,
    TX
  } ctrlStateT;

  ctrlStateT             state;
  logic [CNT_W-1:0]      byteCnt;
  logic                  wrEnReg;
  logic                  rdEnReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0] wrDataReg;
  logic [DATA_WIDTH-1:0] txShift;
  logic [7:0]            txDataReg;
  logic                  txValidReg;
  logic                  errReg;

  logic                  addrInRange;
  logic [DATA_WIDTH-1:0] txShiftNext;

  // An address byte is legal only when every bit above the register
  // address width is zero. Shifting rather than slicing keeps this valid
  // even when ADDR_WIDTH is the full byte.
  assign addrInRange = ((bus.rx_data >> ADDR_WIDTH) == 8'd0);

  // The transmit shift register moves one byte toward bit 0 each time the
  // transmitter takes a byte, so the next byte to offer is always the low
  // byte of the shifted value.
  assign txShiftNext = txShift >> 8;

  // Drive the interface from the registered copies only.
  assign bus.WrEn     = wrEnReg;
  assign bus.RdEn     = rdEnReg;
  assign bus.Address  = addrReg;
  assign bus.WrData   = wrDataReg;
  assign bus.tx_data  = txDataReg;
  assign bus.tx_valid = txValidReg;
  assign bus.err      = errReg;

  // Frame decoder and transaction sequencer. One transition per edge; a
  // received byte is consumed only on an edge where rx_valid is high.
  // The error flag defaults low every cycle so it can only ever pulse.
  // Bytes arriving while a command is executing or data is being sent
  // back are dropped with an error pulse and leave the sequence intact.
  // Address and WrData are deliberately never cleared between frames.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      byteCnt    <= '0;
      wrEnReg    <= 1'b0;
      rdEnReg    <= 1'b0;
      addrReg    <= '0;
      wrDataReg  <= '0;
      txShift    <= '0;
      txDataReg  <= '0;
      txValidReg <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      errReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == WR_CMD) begin
              state <= W_ADDR;
            end else if (bus.rx_data == RD_CMD) begin
              state <= R_ADDR;
            end else begin
              errReg <= 1'b1;
            end
          end
        end

        W_ADDR: begin
          if (bus.rx_valid) begin
            if (addrInRange) begin
              addrReg <= bus.rx_data[ADDR_WIDTH-1:0];
              byteCnt <= '0;
              state   <= W_DATA;
            end else begin
              errReg <= 1'b1;
              state  <= IDLE;
            end
          end
        end

        // Data bytes land in WrData least significant byte first; the
        // write strobe is raised together with the move into WRITE so it
        // is high for exactly that one cycle.
        W_DATA: begin
          if (bus.rx_valid) begin
            for (int k = 0; k < NB; k++) begin
              if (byteCnt == CNT_W'(k)) begin
                wrDataReg[8*k +: 8] <= bus.rx_data;
              end
            end
            if (byteCnt == LAST_BYTE) begin
              wrEnReg <= 1'b1;
              state   <= WRITE;
            end else begin
              byteCnt <= byteCnt + CNT_ONE;
            end
          end
        end

        WRITE: begin
          wrEnReg <= 1'b0;
          state   <= IDLE;
          if (bus.rx_valid) begin
            errReg <= 1'b1;
          end
        end

        R_ADDR: begin
          if (bus.rx_valid) begin
            if (addrInRange) begin
              addrReg <= bus.rx_data[ADDR_WIDTH-1:0];
              rdEnReg <= 1'b1;
              state   <= READ;
            end else begin
              errReg <= 1'b1;
              state  <= IDLE;
            end
          end
        end

        READ: begin
          rdEnReg <= 1'b0;
          state   <= R_WAIT;
          if (bus.rx_valid) begin
            errReg <= 1'b1;
          end
        end

        // The register file presents RdData one edge after RdEn, so it is
        // captured here and the first byte is offered straight away.
        R_WAIT: begin
          txShift    <= bus.RdData;
          txDataReg  <= bus.RdData[7:0];
          txValidReg <= 1'b1;
          byteCnt    <= '0;
          state      <= TX;
          if (bus.rx_valid) begin
            errReg <= 1'b1;
          end
        end

        // tx_data and tx_valid change only on an accepted byte, which
        // keeps them stable under backpressure.
        TX: begin
          if (bus.rx_valid) begin
            errReg <= 1'b1;
          end
          if (bus.tx_ready) begin
            if (byteCnt == LAST_BYTE) begin
              txValidReg <= 1'b0;
              state      <= IDLE;
            end else begin
              byteCnt   <= byteCnt + CNT_ONE;
              txShift   <= txShiftNext;
              txDataReg <= txShiftNext[7:0];
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_file_ctrl
//   Self-checking bench for reg_file_ctrl. The bench plays the serial
//   receiver, the register file and the transmitter. refMem holds what each
//   register must contain according to the frame rules alone; read results
//   coming back over the tx link are compared against it.
// ---------------------------------------------------------------------------
module tb_reg_file_ctrl;

  localparam int         DW     = 16;
  localparam int         AW     = 3;
  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  reg_file_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .WR_CMD    (WR_CMD),
    .RD_CMD    (RD_CMD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] envRf  [8];
  logic [DW-1:0] refMem [8];

  int         wrCount      = 0;
  int         rdCount      = 0;
  int         errCount     = 0;
  int         overlapCount = 0;
  int         stallViol    = 0;
  logic [7:0] txQ[$];
  logic       prevValid    = 1'b0;
  logic       prevReady    = 1'b0;
  logic [7:0] prevData     = 8'h00;

  // Register file model: synchronous write, registered read one edge
  // after RdEn.
  always @(posedge CLK) begin
    if (bus.WrEn) envRf[bus.Address] <= bus.WrData;
    if (bus.RdEn) bus.RdData <= envRf[bus.Address];
  end

  // Passive monitor sampled at the falling edge. Inputs change just after
  // the rising edge, so the values seen here are exactly what the next
  // rising edge will act on.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.WrEn) wrCount++;
      if (bus.RdEn) rdCount++;
      if (bus.err) errCount++;
      if (bus.WrEn && bus.RdEn) overlapCount++;
      if (bus.tx_valid && bus.tx_ready) txQ.push_back(bus.tx_data);
      if (prevValid && !prevReady && (bus.tx_valid !== 1'b1 || bus.tx_data !== prevData))
        stallViol++;
    end
    prevValid = bus.tx_valid;
    prevReady = bus.tx_ready;
    prevData  = bus.tx_data;
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Present one received byte for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    nextCycle();
    bus.rx_valid = 1'b0;
  endtask

  // Sends a full write frame; returns one step after the last data byte,
  // i.e. in the cycle where WrEn should be high.
  task automatic writeFrame(input logic [7:0] addr, input logic [DW-1:0] data);
    applyStimulus(WR_CMD);
    applyStimulus(addr);
    applyStimulus(data[7:0]);
    applyStimulus(data[15:8]);
  endtask

  // Sends a read frame and collects the two returned bytes.
  task automatic readFrame(input logic [7:0] addr, input bit randomReady,
                           output logic [DW-1:0] got, output bit timedOut);
    int base;
    base = txQ.size();
    applyStimulus(RD_CMD);
    applyStimulus(addr);
    timedOut = 1'b1;
    got      = '0;
    for (int c = 0; c < 200; c++) begin
      bus.tx_ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      nextCycle();
      if (txQ.size() >= base + 2 && bus.tx_valid === 1'b0) begin
        timedOut = 1'b0;
        break;
      end
    end
    if (!timedOut) got = {txQ[base+1], txQ[base]};
    bus.tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    RST          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.WrEn, bus.RdEn, bus.tx_valid, bus.err} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0000", {bus.WrEn, bus.RdEn, bus.tx_valid, bus.err});
    end
    checks++;
    if (bus.Address !== 3'd0 || bus.WrData !== 16'h0 || bus.tx_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h/%h/%h exp=0/0000/00", bus.Address, bus.WrData, bus.tx_data);
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    nextCycle();
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    writeFrame(8'h05, 16'h000A);
    refMem[5] = 16'd10;
    checks++;
    if (bus.WrEn !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t1_wren_high got=%b exp=1", bus.WrEn);
    end
    checks++;
    if (bus.Address !== 3'd5 || bus.WrData !== 16'd10) begin
      failures++;
      $display("[TB] FAIL t1_wr_bus got=%h/%h exp=5/000a", bus.Address, bus.WrData);
    end
    nextCycle();
    checks++;
    if (bus.WrEn !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t1_wren_pulse got=%b exp=0", bus.WrEn);
    end
    checks++;
    if (envRf[5] !== refMem[5]) begin
      failures++;
      $display("[TB] FAIL t1_rf5 got=%h exp=%h", envRf[5], refMem[5]);
    end
  endtask

  task automatic test_read();
    int base;
    int rdSnap;
    $display("[TB] test_read");
    bus.tx_ready = 1'b1;
    base   = txQ.size();
    rdSnap = rdCount;
    applyStimulus(RD_CMD);
    applyStimulus(8'h05);
    checks++;
    if (bus.RdEn !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t2_rden_high got=%b exp=1", bus.RdEn);
    end
    nextCycle();
    checks++;
    if (bus.RdEn !== 1'b0 || bus.tx_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t2_wait_cycle got=%b%b exp=00", bus.RdEn, bus.tx_valid);
    end
    nextCycle();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL t2_first_byte got=%b/%h exp=1/0a", bus.tx_valid, bus.tx_data);
    end
    nextCycle();
    nextCycle();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t2_tx_done got=%b exp=0", bus.tx_valid);
    end
    checks++;
    if (txQ.size() < base + 2) begin
      failures++;
      $display("[TB] FAIL t2_bytes got=%0d_bytes exp=2_bytes", txQ.size() - base);
    end else if ({txQ[base+1], txQ[base]} !== refMem[5]) begin
      failures++;
      $display("[TB] FAIL t2_bytes got=%h exp=%h", {txQ[base+1], txQ[base]}, refMem[5]);
    end
    checks++;
    if (rdCount - rdSnap !== 1) begin
      failures++;
      $display("[TB] FAIL t2_rden_count got=%0d exp=1", rdCount - rdSnap);
    end
  endtask

  task automatic test_backpressure();
    int base;
    $display("[TB] test_backpressure");
    writeFrame(8'h02, 16'h1203);
    refMem[2] = 16'h1203;
    nextCycle();
    bus.tx_ready = 1'b0;
    base = txQ.size();
    applyStimulus(RD_CMD);
    applyStimulus(8'h02);
    for (int c = 0; c < 10 && bus.tx_valid !== 1'b1; c++) nextCycle();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h03) begin
        failures++;
        $display("[TB] FAIL t3_hold_%0d got=%b/%h exp=1/03", c, bus.tx_valid, bus.tx_data);
      end
      nextCycle();
    end
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 10 && !(txQ.size() >= base + 2 && bus.tx_valid === 1'b0); c++) nextCycle();
    checks++;
    if (txQ.size() < base + 2) begin
      failures++;
      $display("[TB] FAIL t3_bytes got=%0d_bytes exp=2_bytes", txQ.size() - base);
    end else if ({txQ[base+1], txQ[base]} !== 16'h1203) begin
      failures++;
      $display("[TB] FAIL t3_bytes got=%h exp=1203", {txQ[base+1], txQ[base]});
    end
  endtask

  task automatic test_errors();
    int errSnap;
    int wrSnap;
    $display("[TB] test_errors");
    errSnap = errCount;
    wrSnap  = wrCount;
    applyStimulus(8'h5C);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t4_bad_opcode got=%b exp=1", bus.err);
    end
    nextCycle();
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t4_err_pulse got=%b exp=0", bus.err);
    end
    applyStimulus(WR_CMD);
    applyStimulus(8'h09);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t4_bad_addr got=%b exp=1", bus.err);
    end
    nextCycle();
    writeFrame(8'h02, 16'h0003);
    refMem[2] = 16'h0003;
    checks++;
    if (bus.WrEn !== 1'b1 || bus.Address !== 3'd2 || bus.WrData !== 16'h0003) begin
      failures++;
      $display("[TB] FAIL t4_recover got=%b/%h/%h exp=1/2/0003", bus.WrEn, bus.Address, bus.WrData);
    end
    nextCycle();
    checks++;
    if (wrCount - wrSnap !== 1 || errCount - errSnap !== 2) begin
      failures++;
      $display("[TB] FAIL t4_counts got=wr%0d/err%0d exp=wr1/err2", wrCount - wrSnap, errCount - errSnap);
    end
  endtask

  task automatic test_reset_midframe();
    int wrSnap;
    logic [DW-1:0] got;
    bit timedOut;
    $display("[TB] test_reset_midframe");
    wrSnap = wrCount;
    applyStimulus(WR_CMD);
    applyStimulus(8'h05);
    applyStimulus(8'h0A);
    RST = 1'b0;
    #1;
    checks++;
    if (bus.Address !== 3'd0 || bus.WrData !== 16'h0 || bus.WrEn !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t5_async_reset got=%h/%h/%b exp=0/0000/0", bus.Address, bus.WrData, bus.WrEn);
    end
    nextCycle();
    nextCycle();
    RST = 1'b1;
    nextCycle();
    checks++;
    if (wrCount !== wrSnap || envRf[5] !== refMem[5]) begin
      failures++;
      $display("[TB] FAIL t5_no_write got=%0d/%h exp=%0d/%h", wrCount, envRf[5], wrSnap, refMem[5]);
    end
    readFrame(8'h05, 1'b0, got, timedOut);
    checks++;
    if (timedOut || got !== refMem[5]) begin
      failures++;
      $display("[TB] FAIL t5_read_after got=%h timeout=%b exp=%h", got, timedOut, refMem[5]);
    end
  endtask

  task automatic test_byte_during_tx();
    int base;
    int errSnap;
    $display("[TB] test_byte_during_tx");
    bus.tx_ready = 1'b0;
    base = txQ.size();
    applyStimulus(RD_CMD);
    applyStimulus(8'h05);
    for (int c = 0; c < 10 && bus.tx_valid !== 1'b1; c++) nextCycle();
    errSnap = errCount;
    applyStimulus(8'h77);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t6_err got=%b exp=1", bus.err);
    end
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL t6_tx_intact got=%b/%h exp=1/0a", bus.tx_valid, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 10 && !(txQ.size() >= base + 2 && bus.tx_valid === 1'b0); c++) nextCycle();
    checks++;
    if (txQ.size() < base + 2) begin
      failures++;
      $display("[TB] FAIL t6_bytes got=%0d_bytes exp=2_bytes", txQ.size() - base);
    end else if ({txQ[base+1], txQ[base]} !== refMem[5] || errCount - errSnap !== 1) begin
      failures++;
      $display("[TB] FAIL t6_bytes got=%h/err%0d exp=%h/err1", {txQ[base+1], txQ[base]}, errCount - errSnap, refMem[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [DW-1:0] got;
    bit timedOut;
    $display("[TB] test_back_to_back");
    d = DW'($urandom);
    writeFrame(8'h04, d);
    refMem[4] = d;
    applyStimulus(RD_CMD);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_drop_in_write got=%b exp=1", bus.err);
    end
    readFrame(8'h04, 1'b1, got, timedOut);
    checks++;
    if (timedOut || got !== d) begin
      failures++;
      $display("[TB] FAIL b2b_read got=%h timeout=%b exp=%h", got, timedOut, d);
    end
    d = DW'($urandom);
    writeFrame(8'h06, d);
    refMem[6] = d;
    checks++;
    if (bus.WrEn !== 1'b1 || bus.Address !== 3'd6 || bus.WrData !== d) begin
      failures++;
      $display("[TB] FAIL b2b_write got=%b/%h/%h exp=1/6/%h", bus.WrEn, bus.Address, bus.WrData, d);
    end
    nextCycle();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [DW-1:0] got;
    logic [7:0]    a;
    logic [7:0]    b;
    bit            timedOut;
    int            op;
    int            wrSnap;
    $display("[TB] test_random");
    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom);
      a = 8'(i);
      writeFrame(a, d);
      refMem[i] = d;
      checks++;
      if (bus.WrEn !== 1'b1 || bus.Address !== a[2:0] || bus.WrData !== d) begin
        failures++;
        $display("[TB] FAIL rnd_fill_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.WrEn, bus.Address, bus.WrData, a[2:0], d);
      end
      nextCycle();
    end
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      a  = 8'($urandom_range(0, 7));
      if (op <= 3) begin
        d = DW'($urandom);
        writeFrame(a, d);
        refMem[a[2:0]] = d;
        checks++;
        if (bus.WrEn !== 1'b1 || bus.Address !== a[2:0] || bus.WrData !== d) begin
          failures++;
          $display("[TB] FAIL rnd_write_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.WrEn, bus.Address, bus.WrData, a[2:0], d);
        end
        nextCycle();
      end else if (op <= 7) begin
        readFrame(a, 1'b1, got, timedOut);
        checks++;
        if (timedOut || got !== refMem[a[2:0]]) begin
          failures++;
          $display("[TB] FAIL rnd_read_%0d got=%h timeout=%b exp=%h", i, got, timedOut, refMem[a[2:0]]);
        end
      end else if (op == 8) begin
        b = 8'($urandom_range(0, 255));
        while (b == WR_CMD || b == RD_CMD) b = 8'($urandom_range(0, 255));
        applyStimulus(b);
        checks++;
        if (bus.err !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rnd_opcode_%0d got=%b exp=1", i, bus.err);
        end
        nextCycle();
      end else begin
        wrSnap = wrCount;
        applyStimulus(WR_CMD);
        applyStimulus(8'($urandom_range(8, 255)));
        checks++;
        if (bus.err !== 1'b1) begin
          failures++;
          $display("[TB] FAIL rnd_badaddr_%0d got=%b exp=1", i, bus.err);
        end
        nextCycle();
        checks++;
        if (wrCount !== wrSnap) begin
          failures++;
          $display("[TB] FAIL rnd_badaddr_nowr_%0d got=%0d exp=%0d", i, wrCount, wrSnap);
        end
      end
    end
    checks++;
    if (overlapCount !== 0 || stallViol !== 0) begin
      failures++;
      $display("[TB] FAIL global_rules got=overlap%0d/stall%0d exp=0/0", overlapCount, stallViol);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_errors();
    test_reset_midframe();
    test_byte_during_tx();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
